csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Controller sitting in front of the single write port of the machine-mode CSR file.
- Sequences the multi-CSR updates required on trap entry (mepc, mcause, mtval, mstatus) and on mret (mstatus), one write per cycle.
- Arbitrates that port against ordinary CSR-instruction writes.
- Emits a one-cycle PC redirect to fetch once a sequence completes.

Parameters:
XLEN, 64, width of CSR data, PCs, cause and tval
ADDR_W, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
trap_valid  in  1  trap request (exception or interrupt)
trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
trap_pc  in  XLEN  PC of trapping instruction
trap_tval  in  XLEN  mtval value
mret_valid  in  1  mret request
accept  out  1  combinational; trap/mret accepted this cycle
instr_req_valid  in  1  CSR-instruction write request
instr_req_addr  in  ADDR_W  its destination address
instr_req_data  in  XLEN  its write data
instr_req_ready  out  1  combinational; instruction write accepted this cycle
mstatus_in  in  XLEN  current mstatus from CSR file
mtvec_in  in  XLEN  current mtvec from CSR file
mepc_in  in  XLEN  current mepc from CSR file
csr_write_enable  out  1  registered write strobe to CSR file
csr_dest_addr  out  ADDR_W  registered write address
csr_write_data  out  XLEN  registered write data
redirect_valid  out  1  registered one-cycle redirect pulse
redirect_pc  out  XLEN  registered redirect target
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: state = IDLE. csr_write_enable, csr_dest_addr, csr_write_data, redirect_valid, redirect_pc, busy and all capture registers are 0.
- Reset mid-sequence aborts immediately. No further writes and no redirect are produced.
- States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR.
- Priority in IDLE: trap_valid > mret_valid > instr_req_valid.
  - accept = IDLE & (trap_valid | mret_valid).
  - instr_req_ready = IDLE & !trap_valid & !mret_valid.
  - Outside IDLE, all requests are ignored (accept = 0, instr_req_ready = 0). Requesters hold their requests until accepted.
- Trap acceptance (cycle N):
  - Capture trap_pc, trap_cause and trap_tval.
  - Capture mstatus_in and mtvec_in.
  - Go to T_MEPC.
- Trap sequence, one CSR write per cycle, csr_write_enable = 1 in each write state:
  - N+1, T_MEPC: addr 0x341, data = captured pc & ~1 (bit 0 forced 0).
  - N+2, T_MCAUSE: addr 0x342, data = cause.
  - N+3, T_MTVAL: addr 0x343, data = tval.
  - N+4, T_MSTATUS: addr 0x300, data = captured mstatus with MPIE(7) = old MIE(3), MIE(3) = 0, MPP(12:11) = 2'b11. Other bits unchanged.
  - N+5, T_REDIR: redirect_valid = 1, csr_write_enable = 0, redirect_pc = trap target.
  - N+6: IDLE. A new request may be accepted in N+6.
- Trap target:
  - base = mtvec & ~3.
  - If mtvec[1:0] == 1 and cause[XLEN-1] == 1: target = base + (cause[XLEN-2:0] << 2), truncated to XLEN.
  - Otherwise target = base. mtvec[1:0] values 2 and 3 are treated as direct.
- Mret acceptance (cycle N):
  - Capture mstatus_in and mepc_in.
  - N+1, R_MSTATUS: addr 0x300, data = mstatus with MIE(3) = old MPIE(7), MPIE(7) = 1, MPP(12:11) = 0.
  - N+2, R_REDIR: redirect_valid = 1, redirect_pc = captured mepc.
  - N+3: IDLE.
- Instruction write: when instr_req_valid & instr_req_ready in cycle N, the CSR write appears in N+1 with the given addr and data; state stays IDLE. Back-to-back instruction writes sustain one per cycle.
- No-write cycles: csr_write_enable = 0; csr_dest_addr and csr_write_data hold their previous values.
- redirect_valid is exactly one cycle per sequence; redirect_pc holds its value afterwards.
- Simultaneous trap_valid & mret_valid: the trap wins, and the mret is not consumed.
- Captured values are frozen at acceptance. Input changes during a sequence have no effect.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, busy 0, accept 0, instr_req_ready 1.
- Trap: mtvec_in = 0x8000_0000, mstatus_in = 0x8, cause = 2, pc = 0x8000_0105, tval = 0xDEAD.
  - Writes (0x341, 0x8000_0104), (0x342, 2), (0x343, 0xDEAD), (0x300, 0x1880) in N+1..N+4.
  - N+5: redirect 0x8000_0000.
  - busy 1 in N+1..N+5.
- Vectored interrupt: mtvec_in = 0x8000_0001, cause = 0x8000_0000_0000_0007 -> redirect_pc = 0x8000_001C.
- Mret: mstatus_in = 0x1880, mepc_in = 0x8000_0200 -> N+1 write (0x300, 0x88); N+2 redirect 0x8000_0200; IDLE at N+3.
- Arbitration:
  - instr_req (0x340, 0x55) together with trap_valid -> instr_req_ready 0.
  - The instruction write is issued only in the first IDLE cycle after T_REDIR, and appears the next cycle.
  - Trap and mret together -> trap sequence only.
- Assert rst during T_MCAUSE -> outputs 0 immediately; no mtval/mstatus write and no redirect; IDLE after release.

Source files
------------

// File: rtl/csr_trap_seq.sv
// csr_trap_seq
//   Sits in front of the single write port of the machine-mode CSR file.
//   Trap entry writes mepc, mcause, mtval and mstatus, one per cycle, and then
//   redirects fetch to the trap vector. Mret writes mstatus and then redirects
//   to mepc. Ordinary CSR-instruction writes use the port while the
//   controller is idle.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   trap_valid/cause/pc/tval    trap request and its payload
//   mret_valid                  mret request
//   accept                      trap or mret taken this cycle (comb)
//   instr_req_valid/addr/data   CSR-instruction write request
//   instr_req_ready             instruction write taken this cycle (comb)
//   mstatus_in/mtvec_in/mepc_in current CSR values from the CSR file
//   csr_write_enable/dest_addr/write_data  registered CSR write port
//   redirect_valid/redirect_pc  registered one-cycle fetch redirect
//   busy                        a sequence is in progress
//
// state     | meaning
// IDLE      | arbitrate trap > mret > instruction write
// T_MEPC    | mepc write on the port
// T_MCAUSE  | mcause write on the port
// T_MTVAL   | mtval write on the port
// T_MSTATUS | trap-entry mstatus write on the port
// T_REDIR   | redirect to trap vector
// R_MSTATUS | mret mstatus write on the port
// R_REDIR   | redirect to mepc
module csr_trap_seq #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic              mret_valid,
  output logic              accept,
  input  logic              instr_req_valid,
  input  logic [ADDR_W-1:0] instr_req_addr,
  input  logic [XLEN-1:0]   instr_req_data,
  output logic              instr_req_ready,
  input  logic [XLEN-1:0]   mstatus_in,
  input  logic [XLEN-1:0]   mtvec_in,
  input  logic [XLEN-1:0]   mepc_in,
  output logic              csr_write_enable,
  output logic [ADDR_W-1:0] csr_dest_addr,
  output logic [XLEN-1:0]   csr_write_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR
  } state_t;

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);
  localparam logic [ADDR_W-1:0] A_MTVAL   = ADDR_W'(12'h343);

  state_t            state, state_nxt;
  logic [XLEN-1:0]   cap_cause, cap_tval, cap_mstatus, cap_mtvec, cap_mepc;
  logic              we_nxt, redir_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [XLEN-1:0]   data_nxt, rpc_nxt;
  logic [XLEN-1:0]   trap_ms, mret_ms, base, target;

  // mstatus rewrite on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
  always_comb begin
    trap_ms        = cap_mstatus;
    trap_ms[7]     = cap_mstatus[3];
    trap_ms[3]     = 1'b0;
    trap_ms[12:11] = 2'b11;
  end

  // mret uses the live mstatus: it is written in the cycle right after acceptance
  always_comb begin
    mret_ms        = mstatus_in;
    mret_ms[3]     = mstatus_in[7];
    mret_ms[7]     = 1'b1;
    mret_ms[12:11] = 2'b00;
  end

  // Only mode 1 with an interrupt cause is vectored; modes 2/3 act as direct
  always_comb begin
    base = cap_mtvec & ~XLEN'(3);
    if (cap_mtvec[1:0] == 2'b01 && cap_cause[XLEN-1])
      target = base + {cap_cause[XLEN-3:0], 2'b00};
    else
      target = base;
  end

  assign busy            = (state != IDLE);
  assign accept          = (state == IDLE) & (trap_valid | mret_valid);
  assign instr_req_ready = (state == IDLE) & ~trap_valid & ~mret_valid;

  // Next-state and next values of the registered write/redirect outputs
  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    addr_nxt  = csr_dest_addr;
    data_nxt  = csr_write_data;
    redir_nxt = 1'b0;
    rpc_nxt   = redirect_pc;
    unique case (state)
      IDLE: begin
        if (trap_valid) begin
          state_nxt = T_MEPC;
          we_nxt    = 1'b1;
          addr_nxt  = A_MEPC;
          data_nxt  = trap_pc & ~XLEN'(1);
        end else if (mret_valid) begin
          state_nxt = R_MSTATUS;
          we_nxt    = 1'b1;
          addr_nxt  = A_MSTATUS;
          data_nxt  = mret_ms;
        end else if (instr_req_valid) begin
          we_nxt    = 1'b1;
          addr_nxt  = instr_req_addr;
          data_nxt  = instr_req_data;
        end
      end
      T_MEPC: begin
        state_nxt = T_MCAUSE;
        we_nxt    = 1'b1;
        addr_nxt  = A_MCAUSE;
        data_nxt  = cap_cause;
      end
      T_MCAUSE: begin
        state_nxt = T_MTVAL;
        we_nxt    = 1'b1;
        addr_nxt  = A_MTVAL;
        data_nxt  = cap_tval;
      end
      T_MTVAL: begin
        state_nxt = T_MSTATUS;
        we_nxt    = 1'b1;
        addr_nxt  = A_MSTATUS;
        data_nxt  = trap_ms;
      end
      T_MSTATUS: begin
        state_nxt = T_REDIR;
        redir_nxt = 1'b1;
        rpc_nxt   = target;
      end
      R_MSTATUS: begin
        state_nxt = R_REDIR;
        redir_nxt = 1'b1;
        rpc_nxt   = cap_mepc;
      end
      T_REDIR, R_REDIR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      csr_write_enable <= 1'b0;
      csr_dest_addr    <= '0;
      csr_write_data   <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      state            <= state_nxt;
      csr_write_enable <= we_nxt;
      csr_dest_addr    <= addr_nxt;
      csr_write_data   <= data_nxt;
      redirect_valid   <= redir_nxt;
      redirect_pc      <= rpc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_cause   <= '0;
      cap_tval    <= '0;
      cap_mstatus <= '0;
      cap_mtvec   <= '0;
      cap_mepc    <= '0;
    end else if (state == IDLE) begin
      if (trap_valid) begin
        cap_cause   <= trap_cause;
        cap_tval    <= trap_tval;
        cap_mstatus <= mstatus_in;
        cap_mtvec   <= mtvec_in;
      end else if (mret_valid) begin
        cap_mstatus <= mstatus_in;
        cap_mepc    <= mepc_in;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
module tb_csr_trap_seq;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trap_valid = 1'b0;
  logic [XLEN-1:0]   trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic              mret_valid = 1'b0;
  logic              accept;
  logic              instr_req_valid = 1'b0;
  logic [ADDR_W-1:0] instr_req_addr = '0;
  logic [XLEN-1:0]   instr_req_data = '0;
  logic              instr_req_ready;
  logic [XLEN-1:0]   mstatus_in = '0, mtvec_in = '0, mepc_in = '0;
  logic              csr_write_enable;
  logic [ADDR_W-1:0] csr_dest_addr;
  logic [XLEN-1:0]   csr_write_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [ADDR_W+XLEN-1:0] wq[$];
  logic [XLEN-1:0]        rq[$];

  csr_trap_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid), .accept(accept),
    .instr_req_valid(instr_req_valid), .instr_req_addr(instr_req_addr),
    .instr_req_data(instr_req_data), .instr_req_ready(instr_req_ready),
    .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .csr_write_enable(csr_write_enable), .csr_dest_addr(csr_dest_addr),
    .csr_write_data(csr_write_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] m_trap_ms(input logic [XLEN-1:0] m);
    return (m & ~64'h1888) | (((m >> 3) & 64'h1) << 7) | 64'h1800;
  endfunction

  function automatic logic [XLEN-1:0] m_mret_ms(input logic [XLEN-1:0] m);
    return (m & ~64'h1888) | (((m >> 7) & 64'h1) << 3) | 64'h80;
  endfunction

  function automatic logic [XLEN-1:0] m_target(input logic [XLEN-1:0] tv,
                                               input logic [XLEN-1:0] c);
    logic [XLEN-1:0] b;
    b = tv & ~64'h3;
    if ((tv & 64'h3) == 64'h1 && c[XLEN-1]) return b + (c << 2);
    return b;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard: every write/redirect the DUT emits must match the queue head
  initial begin
    logic [ADDR_W+XLEN-1:0] ew;
    logic [XLEN-1:0]        er;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (csr_write_enable === 1'b1) begin
          n_total++;
          if (wq.size() == 0)
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                     csr_dest_addr, csr_write_data);
          else begin
            ew = wq.pop_front();
            if ({csr_dest_addr, csr_write_data} !== ew)
              $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                       csr_dest_addr, csr_write_data, ew[ADDR_W+XLEN-1:XLEN], ew[XLEN-1:0]);
            else n_pass++;
          end
        end
        if (redirect_valid === 1'b1) begin
          n_total++;
          if (rq.size() == 0)
            $display("FAIL unexpected_redirect: got pc=%h, required no redirect", redirect_pc);
          else begin
            er = rq.pop_front();
            if (redirect_pc !== er)
              $display("FAIL redirect_pc: got %h, required %h", redirect_pc, er);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic push_trap(input logic [XLEN-1:0] tv, ms, c, pc, tval);
    wq.push_back({12'h341, pc & ~64'h1});
    wq.push_back({12'h342, c});
    wq.push_back({12'h343, tval});
    wq.push_back({12'h300, m_trap_ms(ms)});
    rq.push_back(m_target(tv, c));
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    step(); step();
    n_total++;
    if ({csr_write_enable, csr_dest_addr, csr_write_data, redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h rv=%b rpc=%h busy=%b, required all 0",
               csr_write_enable, csr_dest_addr, csr_write_data, redirect_valid, redirect_pc, busy);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({csr_write_enable, redirect_valid, busy, accept, instr_req_ready} !== 5'b00001)
        $display("FAIL idle_outputs: got we=%b rv=%b busy=%b accept=%b ready=%b, required 0 0 0 0 1",
                 csr_write_enable, redirect_valid, busy, accept, instr_req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_trap(input logic [XLEN-1:0] tv, ms, c, pc, tval);
    push_trap(tv, ms, c, pc, tval);
    mtvec_in = tv; mstatus_in = ms; trap_cause = c; trap_pc = pc; trap_tval = tval;
    trap_valid = 1'b1;
    #1;
    n_total++;
    if (accept !== 1'b1 || instr_req_ready !== 1'b0)
      $display("FAIL trap_accept: got accept=%b ready=%b, required 1 0", accept, instr_req_ready);
    else n_pass++;
    step();
    trap_valid = 1'b0;
    // Scramble inputs: captured values must not move
    mtvec_in = {$urandom, $urandom}; mstatus_in = {$urandom, $urandom};
    trap_cause = {$urandom, $urandom}; trap_pc = {$urandom, $urandom};
    trap_tval = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (busy !== 1'b1 || redirect_valid !== (i == 4))
        $display("FAIL trap_busy: cycle N+%0d got busy=%b rv=%b, required 1 %b",
                 i + 1, busy, redirect_valid, (i == 4));
      else n_pass++;
      step();
    end
    n_total++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL trap_done: got busy=%b rv=%b, required 0 0", busy, redirect_valid);
    else n_pass++;
  endtask

  task automatic test_mret(input logic [XLEN-1:0] ms, mepc);
    wq.push_back({12'h300, m_mret_ms(ms)});
    rq.push_back(mepc);
    mstatus_in = ms; mepc_in = mepc; mret_valid = 1'b1;
    #1;
    n_total++;
    if (accept !== 1'b1) $display("FAIL mret_accept: got %b, required 1", accept);
    else n_pass++;
    step();
    mret_valid = 1'b0; mstatus_in = {$urandom, $urandom}; mepc_in = {$urandom, $urandom};
    n_total++;
    if (busy !== 1'b1 || redirect_valid !== 1'b0)
      $display("FAIL mret_n1: got busy=%b rv=%b, required 1 0", busy, redirect_valid);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b1 || redirect_valid !== 1'b1)
      $display("FAIL mret_n2: got busy=%b rv=%b, required 1 1", busy, redirect_valid);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL mret_idle: got busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_arb_instr();
    logic [XLEN-1:0] tv = 64'h4000_0000, ms = 64'h0, c = 64'h5, pc = 64'h4000_0010, tval = 64'h77;
    push_trap(tv, ms, c, pc, tval);
    mtvec_in = tv; mstatus_in = ms; trap_cause = c; trap_pc = pc; trap_tval = tval;
    trap_valid = 1'b1;
    instr_req_valid = 1'b1; instr_req_addr = 12'h340; instr_req_data = 64'h55;
    #1;
    n_total++;
    if (instr_req_ready !== 1'b0 || accept !== 1'b1)
      $display("FAIL arb_trap_wins: got ready=%b accept=%b, required 0 1", instr_req_ready, accept);
    else n_pass++;
    step();
    trap_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (instr_req_ready !== 1'b0)
        $display("FAIL arb_busy_ready: cycle N+%0d got %b, required 0", i + 1, instr_req_ready);
      else n_pass++;
      step();
    end
    n_total++;
    if (instr_req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL arb_ready_idle: got ready=%b busy=%b, required 1 0", instr_req_ready, busy);
    else n_pass++;
    wq.push_back({12'h340, 64'h55});
    step();
    instr_req_valid = 1'b0;
    n_total++;
    if (csr_write_enable !== 1'b1 || csr_dest_addr !== 12'h340 || csr_write_data !== 64'h55)
      $display("FAIL arb_instr_write: got we=%b addr=%h data=%h, required 1 340 55",
               csr_write_enable, csr_dest_addr, csr_write_data);
    else n_pass++;
    step();
    n_total++;
    if (csr_write_enable !== 1'b0 || csr_dest_addr !== 12'h340 || csr_write_data !== 64'h55)
      $display("FAIL hold_after_write: got we=%b addr=%h data=%h, required 0 340 55",
               csr_write_enable, csr_dest_addr, csr_write_data);
    else n_pass++;
  endtask

  task automatic test_trap_mret();
    logic [XLEN-1:0] tv = 64'h8000_0000, ms = 64'h1880, c = 64'h3, pc = 64'h8000_0300;
    push_trap(tv, ms, c, pc, 64'h0);
    wq.push_back({12'h300, m_mret_ms(ms)});
    rq.push_back(64'h8000_0200);
    mtvec_in = tv; mstatus_in = ms; trap_cause = c; trap_pc = pc; trap_tval = 64'h0;
    mepc_in = 64'h8000_0200;
    trap_valid = 1'b1; mret_valid = 1'b1;
    #1;
    n_total++;
    if (accept !== 1'b1) $display("FAIL both_accept: got %b, required 1", accept);
    else n_pass++;
    step();
    trap_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (accept !== 1'b0 || busy !== 1'b1)
        $display("FAIL both_held: cycle N+%0d got accept=%b busy=%b, required 0 1", i + 1, accept, busy);
      else n_pass++;
      step();
    end
    n_total++;
    if (accept !== 1'b1) $display("FAIL held_mret_accept: got %b, required 1", accept);
    else n_pass++;
    step();
    mret_valid = 1'b0;
    step(); step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL both_idle: got busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      instr_req_valid = 1'b1;
      instr_req_addr  = 12'h7C0 + 12'(k);
      instr_req_data  = {$urandom, $urandom};
      #1;
      n_total++;
      if (instr_req_ready !== 1'b1)
        $display("FAIL b2b_ready: write %0d got %b, required 1", k, instr_req_ready);
      else n_pass++;
      wq.push_back({instr_req_addr, instr_req_data});
      step();
    end
    instr_req_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    wq.push_back({12'h341, 64'h9000_0000});
    wq.push_back({12'h342, 64'hB});
    mtvec_in = 64'h9000_0100; mstatus_in = 64'h8; trap_cause = 64'hB;
    trap_pc = 64'h9000_0000; trap_tval = 64'h1234;
    trap_valid = 1'b1;
    step();
    trap_valid = 1'b0;
    step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({csr_write_enable, csr_dest_addr, csr_write_data, redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL mid_reset: got we=%b addr=%h data=%h rv=%b rpc=%h busy=%b, required all 0",
               csr_write_enable, csr_dest_addr, csr_write_data, redirect_valid, redirect_pc, busy);
    else n_pass++;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (busy !== 1'b0 || instr_req_ready !== 1'b1)
        $display("FAIL post_reset_idle: got busy=%b ready=%b, required 0 1", busy, instr_req_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_trap(64'h8000_0000, 64'h8, 64'h2, 64'h8000_0105, 64'hDEAD);
    test_trap(64'h8000_0001, 64'h0, 64'h8000_0000_0000_0007, 64'h8000_0400, 64'h0);
    test_trap(64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0003, 64'h11, 64'h1);
    test_mret(64'h1880, 64'h8000_0200);
    test_mret(64'h0000_0000_0000_1808, 64'h1234_5678_9ABC_DEF0);
    test_arb_instr();
    test_trap_mret();
    test_back_to_back();
    test_reset_mid();
    step(); step();
    n_total++;
    if (wq.size() != 0 || rq.size() != 0)
      $display("FAIL scoreboard_drain: got %0d writes %0d redirects pending, required 0 0",
               wq.size(), rq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
